lvt_bram: RTL and testbench

LVT_BRAM -- requirements
Module: lvt_bram

---
 rtl/lvt_bram.sv | 72 +++++++
 tb/tb_lvt_bram.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lvt_bram.sv
// Two-write/one-read memory: one single-write bank per write port,
// with a live value table selecting the bank holding the newest word.
module lvt_bram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr0_en,
    input  logic [ADDR_WIDTH-1:0] wr0_addr,
    input  logic [DATA_WIDTH-1:0] wr0_data,
    input  logic                  wr1_en,
    input  logic [ADDR_WIDTH-1:0] wr1_addr,
    input  logic [DATA_WIDTH-1:0] wr1_data,
    input  logic                  rd0_en,
    input  logic [ADDR_WIDTH-1:0] rd0_addr,
    output logic [DATA_WIDTH-1:0] rd0_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] bank0 [DEPTH];
    logic [DATA_WIDTH-1:0] bank1 [DEPTH];
    logic [DEPTH-1:0]      live;
    logic [DEPTH-1:0]      valid;
    logic [DATA_WIDTH-1:0] rd_sel;

    always_ff @(posedge clk) begin
        if (rst && wr0_en) begin
            bank0[wr0_addr] <= wr0_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && wr1_en) begin
            bank1[wr1_addr] <= wr1_data;
        end
    end

    // Port 1 is assigned last so it owns the LVT entry on a same-address collision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            live  <= '0;
            valid <= '0;
        end else begin
            if (wr0_en) begin
                live[wr0_addr]  <= 1'b0;
                valid[wr0_addr] <= 1'b1;
            end
            if (wr1_en) begin
                live[wr1_addr]  <= 1'b1;
                valid[wr1_addr] <= 1'b1;
            end
        end
    end

    always_comb begin
        rd_sel = '0;
        if (valid[rd0_addr]) begin
            rd_sel = live[rd0_addr] ? bank1[rd0_addr] : bank0[rd0_addr];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd0_data <= '0;
        end else if (rd0_en) begin
            rd0_data <= rd_sel;
        end
    end

endmodule

// File: tb/tb_lvt_bram.sv
// Directed self-checking bench for lvt_bram.
// Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
module tb_lvt_bram;

    localparam int DW = 32;
    localparam int AW = 7;

    logic          clk;
    logic          rst;
    logic          wr0_en;
    logic [AW-1:0] wr0_addr;
    logic [DW-1:0] wr0_data;
    logic          wr1_en;
    logic [AW-1:0] wr1_addr;
    logic [DW-1:0] wr1_data;
    logic          rd0_en;
    logic [AW-1:0] rd0_addr;
    logic [DW-1:0] rd0_data;

    int n_cmp;
    int n_bad;

    lvt_bram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr0_en   (wr0_en),
        .wr0_addr (wr0_addr),
        .wr0_data (wr0_data),
        .wr1_en   (wr1_en),
        .wr1_addr (wr1_addr),
        .wr1_data (wr1_data),
        .rd0_en   (rd0_en),
        .rd0_addr (rd0_addr),
        .rd0_data (rd0_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    // One clock cycle with the given inputs; returns 1 ns after the rising edge.
    task automatic cyc(input logic w0e, input int w0a, input int w0d,
                       input logic w1e, input int w1a, input int w1d,
                       input logic re, input int ra);
        @(negedge clk);
        wr0_en   = w0e;
        wr0_addr = AW'(w0a);
        wr0_data = DW'(w0d);
        wr1_en   = w1e;
        wr1_addr = AW'(w1a);
        wr1_data = DW'(w1d);
        rd0_en   = re;
        rd0_addr = AW'(ra);
        @(posedge clk);
        #1;
        wr0_en = 1'b0;
        wr1_en = 1'b0;
        rd0_en = 1'b0;
    endtask

    task automatic wr0(input int a, input int d);
        cyc(1'b1, a, d, 1'b0, 0, 0, 1'b0, 0);
    endtask

    task automatic wr1(input int a, input int d);
        cyc(1'b0, 0, 0, 1'b1, a, d, 1'b0, 0);
    endtask

    task automatic rd(input int a);
        cyc(1'b0, 0, 0, 1'b0, 0, 0, 1'b1, a);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        cyc(1'b1, 10, 77, 1'b1, 11, 88, 1'b1, 10);
        n_cmp++;
        if (rd0_data !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_state: got %0d want 0", rd0_data);
        end
        @(negedge clk);
        rst = 1'b1;
        rd(10);
        n_cmp++;
        if (rd0_data !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_ignores_wr0: got %0d want 0", rd0_data);
        end
        rd(11);
        n_cmp++;
        if (rd0_data !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_ignores_wr1: got %0d want 0", rd0_data);
        end
    endtask

    task automatic test_basic;
        wr0(10, 5);
        wr1(20, 10);
        rd(10);
        n_cmp++;
        if (rd0_data !== 32'd5) begin
            n_bad++;
            $display("FAIL basic_rd10: got %0d want 5", rd0_data);
        end
        rd(20);
        n_cmp++;
        if (rd0_data !== 32'd10) begin
            n_bad++;
            $display("FAIL basic_rd20: got %0d want 10", rd0_data);
        end
    endtask

    task automatic test_unwritten;
        rd(5);
        n_cmp++;
        if (rd0_data !== 32'd0) begin
            n_bad++;
            $display("FAIL unwritten_rd5: got %0d want 0", rd0_data);
        end
        wr0(90, 123);
        wr1(100, 456);
        rd(95);
        n_cmp++;
        if (rd0_data !== 32'd0) begin
            n_bad++;
            $display("FAIL unwritten_rd95: got %0d want 0", rd0_data);
        end
        rd(100);
        n_cmp++;
        if (rd0_data !== 32'd456) begin
            n_bad++;
            $display("FAIL neighbour_rd100: got %0d want 456", rd0_data);
        end
    endtask

    task automatic test_last_writer;
        wr0(50, 25);
        wr1(50, 30);
        rd(50);
        n_cmp++;
        if (rd0_data !== 32'd30) begin
            n_bad++;
            $display("FAIL last_writer_p1: got %0d want 30", rd0_data);
        end
        wr0(50, 7);
        rd(50);
        n_cmp++;
        if (rd0_data !== 32'd7) begin
            n_bad++;
            $display("FAIL last_writer_p0: got %0d want 7", rd0_data);
        end
    endtask

    task automatic test_simultaneous;
        cyc(1'b1, 60, 11, 1'b1, 60, 22, 1'b0, 0);
        rd(60);
        n_cmp++;
        if (rd0_data !== 32'd22) begin
            n_bad++;
            $display("FAIL same_addr_p1_wins: got %0d want 22", rd0_data);
        end
        cyc(1'b1, 70, 35, 1'b1, 80, 40, 1'b0, 0);
        rd(70);
        n_cmp++;
        if (rd0_data !== 32'd35) begin
            n_bad++;
            $display("FAIL dual_rd70: got %0d want 35", rd0_data);
        end
        rd(80);
        n_cmp++;
        if (rd0_data !== 32'd40) begin
            n_bad++;
            $display("FAIL dual_rd80: got %0d want 40", rd0_data);
        end
    endtask

    task automatic test_rbw_hold;
        wr0(30, 15);
        cyc(1'b1, 30, 99, 1'b0, 0, 0, 1'b1, 30);
        n_cmp++;
        if (rd0_data !== 32'd15) begin
            n_bad++;
            $display("FAIL rbw_old: got %0d want 15", rd0_data);
        end
        rd(30);
        n_cmp++;
        if (rd0_data !== 32'd99) begin
            n_bad++;
            $display("FAIL rbw_new: got %0d want 99", rd0_data);
        end
        cyc(1'b0, 0, 0, 1'b0, 0, 0, 1'b0, 10);
        n_cmp++;
        if (rd0_data !== 32'd99) begin
            n_bad++;
            $display("FAIL hold: got %0d want 99", rd0_data);
        end
        cyc(1'b0, 0, 0, 1'b1, 30, 44, 1'b1, 30);
        n_cmp++;
        if (rd0_data !== 32'd99) begin
            n_bad++;
            $display("FAIL rbw_p1_old: got %0d want 99", rd0_data);
        end
        rd(30);
        n_cmp++;
        if (rd0_data !== 32'd44) begin
            n_bad++;
            $display("FAIL rbw_p1_new: got %0d want 44", rd0_data);
        end
    endtask

    task automatic test_reset_mid;
        int addrs [5] = '{10, 20, 50, 70, 30};
        rd(20);
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (rd0_data !== 32'd0) begin
            n_bad++;
            $display("FAIL async_clear: got %0d want 0", rd0_data);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rd(addrs[i]);
            n_cmp++;
            if (rd0_data !== 32'd0) begin
                n_bad++;
                $display("FAIL mid_reset_rd%0d: got %0d want 0",
                         addrs[i], rd0_data);
            end
        end
        wr1(10, 321);
        rd(10);
        n_cmp++;
        if (rd0_data !== 32'd321) begin
            n_bad++;
            $display("FAIL rewrite_after_reset: got %0d want 321", rd0_data);
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        rst      = 1'b0;
        wr0_en   = 1'b0;
        wr0_addr = '0;
        wr0_data = '0;
        wr1_en   = 1'b0;
        wr1_addr = '0;
        wr1_data = '0;
        rd0_en   = 1'b0;
        rd0_addr = '0;
        test_reset();
        test_basic();
        test_unwritten();
        test_last_writer();
        test_simultaneous();
        test_rbw_hold();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
